// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download bus: state encoding, default
// address width and the ioctl_index values understood by the emu loaders.
package ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    localparam logic [7:0] IDX_BOOT_ROM = 8'd0;
    localparam logic [7:0] IDX_CART     = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_STROBE,
        ST_GAP,
        ST_TAIL
    } state_t;

endpackage

// File: rtl/ioctl_download_sender_if.sv
// Byte stream in plus ioctl download bus out. The master side is the sender,
// the slave side is the byte source / ioctl receiver.
interface ioctl_download_sender_if import ioctl_pkg::*; #(
    parameter int ADDR_W = IOCTL_ADDR_W
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;

    modport master (
        input  in_valid, in_data, ioctl_wait,
        output in_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );

    modport slave (
        output in_valid, in_data, ioctl_wait,
        input  in_ready, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
    );

endinterface

// File: rtl/ioctl_download_sender.sv
// Drives an ioctl download window from a valid/ready byte stream. Each byte is
// fetched, strobed for one cycle, then followed by WR_GAP idle cycles; the
// window is held TAIL cycles after the last strobe before done pulses.
module ioctl_download_sender import ioctl_pkg::*; #(
    parameter int ADDR_W = IOCTL_ADDR_W,
    parameter int WR_GAP = 3,
    parameter int TAIL   = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        start_index,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [ADDR_W-1:0] start_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    ioctl_download_sender_if.master bus
);

    // Pacing counter is shared between GAP and TAIL; both end on these values.
    localparam logic [7:0] GAP_LAST  = 8'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic [7:0] TAIL_LAST = 8'(TAIL - 1);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_n;
    logic [ADDR_W-1:0] rem_q, rem_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              download_q, download_n;
    logic              wr_q, wr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        dout_q, dout_n;
    logic [7:0]        index_q, index_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              aborted_q, aborted_n;
    logic              fire;

    // in_ready follows ioctl_wait within the cycle so back-pressure never lets
    // a byte through; it is also held low when an abort is about to end FETCH.
    assign bus.in_ready = (state_q == ST_FETCH) & ~bus.ioctl_wait & ~abort;
    assign fire         = bus.in_valid & bus.in_ready;

    assign bus.ioctl_download = download_q;
    assign bus.ioctl_wr       = wr_q;
    assign bus.ioctl_addr     = addr_q;
    assign bus.ioctl_dout     = dout_q;
    assign bus.ioctl_index    = index_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign aborted            = aborted_q;

    // State and all registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            download_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cur_addr_q <= cur_addr_n;
            rem_q      <= rem_n;
            cnt_q      <= cnt_n;
            download_q <= download_n;
            wr_q       <= wr_n;
            addr_q     <= addr_n;
            dout_q     <= dout_n;
            index_q    <= index_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            aborted_q  <= aborted_n;
        end
    end

    // Next-state and next-output logic; wr and done are single-cycle pulses.
    always_comb begin
        state_n    = state_q;
        cur_addr_n = cur_addr_q;
        rem_n      = rem_q;
        cnt_n      = cnt_q;
        download_n = download_q;
        wr_n       = 1'b0;
        addr_n     = addr_q;
        dout_n     = dout_q;
        index_n    = index_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        aborted_n  = aborted_q;

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless here, so start always wins
                if (start) begin
                    index_n    = start_index;
                    cur_addr_n = start_base;
                    rem_n      = start_len;
                    busy_n     = 1'b1;
                    aborted_n  = 1'b0;
                    download_n = 1'b1;
                    state_n    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_n = '0;
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = ST_TAIL;
                end else if (rem_q == '0) begin
                    state_n = ST_TAIL;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cnt_n = '0;
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = ST_TAIL;
                end else if (fire) begin
                    dout_n  = bus.in_data;
                    addr_n  = cur_addr_q;
                    wr_n    = 1'b1;
                    state_n = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // the strobe is already on the bus; an abort here only cuts
                // the transfer short after it
                cur_addr_n = cur_addr_q + 1'b1;
                rem_n      = rem_q - 1'b1;
                cnt_n      = '0;
                if (abort) begin
                    aborted_n = 1'b1;
                    state_n   = ST_TAIL;
                end else if (rem_q == ADDR_W'(1)) begin
                    state_n = ST_TAIL;
                end else if (WR_GAP > 0) begin
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    aborted_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_TAIL;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_FETCH;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            ST_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    cnt_n      = '0;
                    download_n = 1'b0;
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    state_n    = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ioctl_download_sender.sv
// Scoreboard bench: every accepted stream byte pushes its expected
// {address, data} pair; every ioctl_wr strobe pops and compares one.
module tb_ioctl_download_sender;
    import ioctl_pkg::*;

    localparam int AW  = 25;
    localparam int GAP = 3;
    localparam int TL  = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    start_index = '0;
    logic [AW-1:0] start_base = '0;
    logic [AW-1:0] start_len = '0;
    logic          busy, done, aborted;

    ioctl_download_sender_if #(.ADDR_W(AW)) bus ();

    ioctl_download_sender #(.ADDR_W(AW), .WR_GAP(GAP), .TAIL(TL)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .start       (start),
        .start_index (start_index),
        .start_base  (start_base),
        .start_len   (start_len),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .bus         (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    src[$];
    logic [AW+7:0] exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    logic [7:0]    exp_idx = '0;

    int   strobe_cnt = 0, done_cnt = 0, dl_cycles = 0, idx_bad = 0, rdy_viol = 0;
    int   first_cyc = 0, last_cyc = 0, min_sp = 0, max_sp = 0, start_cyc = 0;
    logic ab_at_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Byte source: presents the queue head, and records the expected strobe
    // whenever a handshake will complete on the coming rising edge.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        forever begin
            @(negedge clk_sys);
            #1;
            bus.in_valid = (src.size() > 0);
            bus.in_data  = (src.size() > 0) ? src[0] : 8'h00;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({exp_addr, src[0]});
                void'(src.pop_front());
                exp_addr = exp_addr + 1'b1;
            end
        end
    end

    // Monitor: scoreboard compare on each strobe, plus window bookkeeping.
    initial begin
        logic [AW+7:0] e;
        int sp;
        forever begin
            @(negedge clk_sys);
            if (bus.ioctl_download === 1'b1) begin
                dl_cycles++;
                if (bus.ioctl_index !== exp_idx) idx_bad++;
            end
            if (bus.ioctl_wr === 1'b1) begin
                if (strobe_cnt == 0) first_cyc = cyc;
                else begin
                    sp = cyc - last_cyc;
                    if (sp < min_sp) min_sp = sp;
                    if (sp > max_sp) max_sp = sp;
                end
                last_cyc = cyc;
                strobe_cnt++;
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", 64'(bus.ioctl_addr), 64'(e[AW+7:8]));
                    chk("sb_data", 64'(bus.ioctl_dout), 64'(e[7:0]));
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                ab_at_done = aborted;
            end
            #3;
            if (bus.in_ready === 1'b1 && bus.ioctl_wait === 1'b1) rdy_viol++;
        end
    end

    task automatic push_bytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) src.push_back(first + 8'(i));
    endtask

    task automatic start_xfer(input logic [7:0] idx, input logic [AW-1:0] base,
                              input logic [AW-1:0] len, input logic ab);
        @(negedge clk_sys);
        strobe_cnt = 0; done_cnt = 0; dl_cycles = 0; idx_bad = 0; rdy_viol = 0;
        min_sp = 1000; max_sp = 0;
        exp_idx = idx; exp_addr = base; start_cyc = cyc + 1;
        start = 1'b1; start_index = idx; start_base = base; start_len = len; abort = ab;
        @(negedge clk_sys);
        start = 1'b0; abort = 1'b0;
        #2;
        chk("busy_after_start", 64'(busy), 1);
        chk("aborted_clr_on_start", 64'(aborted), 0);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            @(negedge clk_sys); #2; k++;
        end
        chk("strobe_timeout", 64'(strobe_cnt >= n), 1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk_sys); #2; k++;
        end
        chk("done_timeout", 64'(done_cnt > 0), 1);
        repeat (3) @(negedge clk_sys);
        #2;
        chk("done_once", 64'(done_cnt), 1);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_download", 64'(bus.ioctl_download), 0);
        chk("index_in_window", 64'(idx_bad), 0);
    endtask

    initial begin
        int s0;
        bus.ioctl_wait = 1'b0;
        #1;
        chk("rst_download", 64'(bus.ioctl_download), 0);
        chk("rst_wr", 64'(bus.ioctl_wr), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_aborted", 64'(aborted), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_addr", 64'(bus.ioctl_addr), 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        // basic 4-byte transfer; a start pulse mid-transfer must be ignored
        src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC); src.push_back(8'hDD);
        start_xfer(IDX_CART, '0, AW'(4), 1'b0);
        wait_strobes(2, 100);
        @(negedge clk_sys);
        start = 1'b1; start_index = 8'h07; start_len = AW'(9);
        @(negedge clk_sys);
        start = 1'b0;
        wait_done(200);
        chk("t1_strobes", 64'(strobe_cnt), 4);
        chk("t1_first_latency", 64'(first_cyc - start_cyc), 2);
        chk("t1_min_spacing", 64'(min_sp), GAP + 2);
        chk("t1_max_spacing", 64'(max_sp), GAP + 2);
        chk("t1_aborted", 64'(ab_at_done), 0);

        // zero length: SETUP plus TAIL only
        start_xfer(IDX_BOOT_ROM, AW'(25'h100), '0, 1'b0);
        wait_done(50);
        chk("t2_download_cycles", 64'(dl_cycles), 1 + TL);
        chk("t2_strobes", 64'(strobe_cnt), 0);

        // receiver back-pressure after the 2nd byte
        push_bytes(4, 8'h01);
        start_xfer(IDX_CART, AW'(25'h40), AW'(4), 1'b0);
        wait_strobes(2, 100);
        @(negedge clk_sys);
        bus.ioctl_wait = 1'b1;
        #2 s0 = strobe_cnt;
        repeat (10) @(negedge clk_sys);
        bus.ioctl_wait = 1'b0;
        #2;
        chk("t3_wr_during_wait", 64'(strobe_cnt), 64'(s0));
        wait_done(200);
        chk("t3_strobes", 64'(strobe_cnt), 4);
        chk("t3_ready_during_wait", 64'(rdy_viol), 0);

        // address wrap; abort issued together with start is ignored
        push_bytes(4, 8'h50);
        start_xfer(IDX_CART, AW'(25'h1FFFFFE), AW'(4), 1'b1);
        wait_done(200);
        chk("t4_strobes", 64'(strobe_cnt), 4);
        chk("t4_aborted", 64'(ab_at_done), 0);

        // abort after the 2nd strobe of 8
        push_bytes(8, 8'h80);
        start_xfer(IDX_BOOT_ROM, AW'(25'h200), AW'(8), 1'b0);
        wait_strobes(2, 100);
        @(negedge clk_sys);
        abort = 1'b1;
        @(negedge clk_sys);
        abort = 1'b0;
        wait_done(100);
        chk("t5_strobes", 64'(strobe_cnt), 2);
        chk("t5_aborted_at_done", 64'(ab_at_done), 1);
        chk("t5_aborted_held", 64'(aborted), 1);
        src.delete();

        // asynchronous reset in the middle of a transfer
        push_bytes(8, 8'hC0);
        start_xfer(IDX_CART, AW'(25'h300), AW'(8), 1'b0);
        wait_strobes(1, 100);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_download", 64'(bus.ioctl_download), 0);
        chk("t6_rst_wr", 64'(bus.ioctl_wr), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        src.delete();
        exp_q.delete();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        push_bytes(2, 8'hE0);
        start_xfer(IDX_CART, AW'(25'h300), AW'(2), 1'b0);
        wait_done(100);
        chk("t6_post_reset_strobes", 64'(strobe_cnt), 2);

        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
